// File: rtl/dsp_requant.sv
// dsp_requant
//   Requantizes signed 48-bit DSP accumulator results into OUT_W-bit signed
//   activations: unsigned scale multiply, round-half-up arithmetic right
//   shift, zero-point add and saturation. The datapath is three lock-step
//   stages with valid/ready on both sides. The scale, shift and zero-point
//   are snapshotted into S1 with each accepted beat. A saturating event
//   counter tracks clamped beats taken by the consumer.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   cfg_we     load cfg_scale / cfg_shift / cfg_zp into the config registers
//   cfg_scale  unsigned scale (SCALE_W)
//   cfg_shift  right-shift amount (SHIFT_W)
//   cfg_zp     signed zero-point (OUT_W)
//   in_valid   input beat valid
//   in_ready   stage can accept a beat (combinational)
//   in_data    signed accumulator value (IN_W)
//   out_valid  output beat valid
//   out_ready  consumer accepts output
//   out_data   signed requantized result (OUT_W)
//   out_sat    this output beat was clamped
//   sat_count  saturating count of clamped beats taken by the consumer
//   sat_clr    clear sat_count (wins over a same-cycle increment)
module dsp_requant #(
  parameter int IN_W    = 48,
  parameter int SCALE_W = 16,
  parameter int SHIFT_W = 6,
  parameter int OUT_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic        [SCALE_W-1:0] cfg_scale,
  input  logic        [SHIFT_W-1:0] cfg_shift,
  input  logic signed [OUT_W-1:0]   cfg_zp,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [IN_W-1:0]    in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_sat,
  output logic        [CNT_W-1:0]   sat_count,
  input  logic                      sat_clr
);

  // Exact product width: signed input times a zero-extended unsigned scale.
  localparam int PW = IN_W + SCALE_W + 1;

  // Round half toward +inf, then arithmetic shift. The bias add is done one
  // bit wider so it can never wrap, whatever the product magnitude.
  function automatic logic signed [PW-1:0] round_shift(
    input logic signed [PW-1:0]  p,
    input logic [SHIFT_W-1:0]    sh
  );
    logic        [PW:0] half;
    logic signed [PW:0] biased;
    if (sh == '0) return p;
    half   = {{PW{1'b0}}, 1'b1} << (sh - SHIFT_W'(1));
    biased = $signed({p[PW-1], p}) + $signed(half);
    return PW'(biased >>> sh);
  endfunction

  // Zero-point add and clamp to the OUT_W signed range.
  // Returns {clamped_flag, value}.
  function automatic logic [OUT_W:0] sat_clamp(
    input logic signed [PW-1:0]    r,
    input logic signed [OUT_W-1:0] zp
  );
    logic signed [PW:0] t;
    logic signed [PW:0] hi;
    logic signed [PW:0] lo;
    t  = $signed({r[PW-1], r}) + $signed((PW+1)'(zp));
    hi = $signed({{(PW+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}});
    lo = $signed({{(PW+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}});
    if (t > hi)      return {1'b1, hi[OUT_W-1:0]};
    else if (t < lo) return {1'b1, lo[OUT_W-1:0]};
    else             return {1'b0, t[OUT_W-1:0]};
  endfunction

  logic                      adv;

  logic        [SCALE_W-1:0] scale_q;
  logic        [SHIFT_W-1:0] shift_q;
  logic signed [OUT_W-1:0]   zp_q;

  logic                      vld_p1_q;
  logic signed [PW-1:0]      prod_p1_d;
  logic signed [PW-1:0]      prod_p1_q;
  logic        [SHIFT_W-1:0] shift_p1_q;
  logic signed [OUT_W-1:0]   zp_p1_q;

  logic                      vld_p2_q;
  logic signed [PW-1:0]      rnd_p2_d;
  logic signed [PW-1:0]      rnd_p2_q;
  logic signed [OUT_W-1:0]   zp_p2_q;

  logic                      vld_p3_q;
  logic        [OUT_W:0]     clamp_p3_d;
  logic signed [OUT_W-1:0]   data_p3_q;
  logic                      sat_p3_q;

  logic        [CNT_W-1:0]   sat_cnt_d;
  logic        [CNT_W-1:0]   sat_cnt_q;

  // The whole pipe moves as one: a stalled output freezes every stage, so
  // bubbles stay where they are.
  assign adv      = !vld_p3_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    prod_p1_d  = $signed(PW'(in_data)) * $signed(PW'({1'b0, scale_q}));
    rnd_p2_d   = round_shift(prod_p1_q, shift_p1_q);
    clamp_p3_d = sat_clamp(rnd_p2_q, zp_p2_q);
  end

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (vld_p3_q && out_ready && sat_p3_q && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end
  end

  // Config registers; a beat accepted on the same edge as cfg_we still sees
  // the old values because S1 samples the register outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scale_q <= SCALE_W'(1);
      shift_q <= '0;
      zp_q    <= '0;
    end else if (cfg_we) begin
      scale_q <= cfg_scale;
      shift_q <= cfg_shift;
      zp_q    <= cfg_zp;
    end
  end

  // ---- S1: scale multiply, config snapshot ----
  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      prod_p1_q  <= prod_p1_d;
      shift_p1_q <= shift_q;
      zp_p1_q    <= zp_q;
    end
  end

  // ---- S2: rounding right shift ----
  always_ff @(posedge clk) begin
    if (adv && vld_p1_q) begin
      rnd_p2_q <= rnd_p2_d;
      zp_p2_q  <= zp_p1_q;
    end
  end

  // ---- S3: zero-point, clamp, output register; stage valids ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      data_p3_q <= '0;
      sat_p3_q  <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
      if (adv) begin
        vld_p1_q <= in_valid;
        vld_p2_q <= vld_p1_q;
        vld_p3_q <= vld_p2_q;
        // Only real beats reach the output, so out_data is stable across bubbles.
        if (vld_p2_q) begin
          data_p3_q <= clamp_p3_d[OUT_W-1:0];
          sat_p3_q  <= clamp_p3_d[OUT_W];
        end
      end
    end
  end

  assign out_valid = vld_p3_q;
  assign out_data  = data_p3_q;
  assign out_sat   = sat_p3_q;
  assign sat_count = sat_cnt_q;

endmodule
